// File: rtl/core_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_host_pkg
// Description : Shared types and constants for the core host sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package core_host_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int DUMP_LEN_MAX = 1 << ADDR_W_DEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DUMP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/core_host_skid.sv
`default_nettype none
// ============================================================================
// Module      : core_host_skid
// Description : One-entry output register with valid/ready handshake. It
//               accepts a new word whenever it is empty or being drained.
// Revision    : 1.0 - initial release
// ============================================================================
module core_host_skid
    import core_host_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic              adv_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              last_q,  last_d;

    // The register may take a new word when empty or when its word leaves now.
    assign adv_o = ~valid_q | out_ready_i;

    // Load the incoming word on an advance; otherwise hold contents stable.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (en_i && adv_o) begin
            valid_d = in_valid_i;
            data_d  = in_data_i;
            last_d  = in_valid_i & in_last_i;
        end
    end

    // Output register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/core_host_seq.sv
`default_nettype none
// ============================================================================
// Module      : core_host_seq
// Description : Host-side initiator for the core start/done handshake.
//               Preloads data memory from a byte stream, runs the core until
//               done or timeout, then streams a window of memory back out.
// Revision    : 1.0 - initial release
// ============================================================================
module core_host_seq
    import core_host_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LOAD_BASE = 0,
    parameter int DUMP_BASE = 0,
    parameter int DUMP_LEN  = 16,
    parameter int TIMEOUT   = 4096,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              start,
    input  logic              done,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  cycles,
    output logic              timeout,
    output logic              fin
);

    localparam logic [ADDR_W-1:0] LOAD_BASE_C = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] DUMP_BASE_C = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W:0]   LEN_C       = (ADDR_W+1)'(DUMP_LEN);
    localparam logic [ADDR_W:0]   LAST_IDX_C  = LEN_C - (ADDR_W+1)'(1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);

    state_t              state_q,   state_d;
    logic [ADDR_W-1:0]   ptr_q,     ptr_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [CNT_W-1:0]    cycles_q,  cycles_d;
    logic                timeout_q, timeout_d;
    logic                fin_q,     fin_d;
    logic [ADDR_W:0]     fcnt_q,    fcnt_d;   // words whose read has been issued
    logic [ADDR_W:0]     lcnt_q,    lcnt_d;   // words loaded into the output register
    logic                rdv_q,     rdv_d;    // mem_rdata holds a requested word

    logic w_xfer;
    logic w_dump;
    logic w_adv;
    logic w_issue;
    logic w_sk_last;
    logic w_out_done;

    assign w_xfer     = (state_q == ST_LOAD) & in_valid;
    assign w_dump     = (state_q == ST_DUMP);
    assign w_issue    = w_dump & w_adv & (fcnt_q != LEN_C);
    assign w_sk_last  = (lcnt_q == LAST_IDX_C);
    assign w_out_done = out_valid & out_ready & out_last;

    core_host_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .en_i        (w_dump),
        .in_valid_i  (rdv_q),
        .in_data_i   (mem_rdata),
        .in_last_i   (w_sk_last),
        .adv_o       (w_adv),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last)
    );

    // Next-state and datapath updates for the session sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        fin_d     = 1'b0;
        fcnt_d    = fcnt_q;
        lcnt_d    = lcnt_q;
        rdv_d     = rdv_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    ptr_d     = LOAD_BASE_C;
                    timeout_d = 1'b0;
                    cycles_d  = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (in_last) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (done) begin
                    cycles_d = cnt_q;
                    state_d  = ST_DRAIN;
                end else if (cnt_q == TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    cycles_d  = TIMEOUT_C;
                    state_d   = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                ptr_d   = DUMP_BASE_C;
                fcnt_d  = '0;
                lcnt_d  = '0;
                rdv_d   = 1'b0;
                state_d = ST_DUMP;
            end
            ST_DUMP: begin
                if (w_adv) begin
                    rdv_d = w_issue;
                    if (rdv_q) begin
                        lcnt_d = lcnt_q + (ADDR_W+1)'(1);
                    end
                end
                if (w_issue) begin
                    ptr_d  = ptr_q + ADDR_W'(1);
                    fcnt_d = fcnt_q + (ADDR_W+1)'(1);
                end
                if (w_out_done) begin
                    fin_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= LOAD_BASE_C;
            cnt_q     <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            fin_q     <= 1'b0;
            fcnt_q    <= '0;
            lcnt_q    <= '0;
            rdv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            fin_q     <= fin_d;
            fcnt_q    <= fcnt_d;
            lcnt_q    <= lcnt_d;
            rdv_q     <= rdv_d;
        end
    end

    // Start follows the state register so reset drops it on the next edge.
    assign start     = (state_q == ST_RUN);
    assign mem_sel   = ~start;
    assign in_ready  = (state_q == ST_LOAD);
    assign mem_we    = w_xfer;
    assign mem_wdata = in_data;
    // While the output register stalls, re-present the in-flight address so
    // the returned word is still on mem_rdata when the register frees up.
    assign mem_addr  = (w_dump && !w_adv) ? (ptr_q - ADDR_W'(1)) : ptr_q;
    assign cycles    = cycles_q;
    assign timeout   = timeout_q;
    assign fin       = fin_q;

endmodule
`default_nettype wire
